clock_tick_ctrl: RTL and testbench
==================================

# clock_tick_ctrl

Sequencing controller for the digital-clock demo. Generates the one-cycle count pulses that drive the cascaded seconds, minutes and hours counters, and converts each counter's level-style overflow flag into a single carry pulse for the next stage. It also runs a three-state time-set mode driven by two debounced push-buttons. The block sits between the board buttons and the counter chain. It replaces ad-hoc glue logic that was wired directly into the counters.

## Interface
- TICKS_PER_SEC, default 1000: clock cycles per second tick; must be ≥ 2. Prescaler width is $clog2(TICKS_PER_SEC).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low forces reset immediately; release is synchronous to clk.
- mode_btn_i  input  1  debounced mode button, asynchronous to clk, active-high.
- inc_btn_i  input  1  debounced increment button, asynchronous to clk, active-high.
- sec_cout_i  input  1  overflow flag from the seconds counter. Level signal that stays high until that counter's next pulse.
- min_cout_i  input  1  overflow flag from the minutes counter, same behaviour.
- sec_pulse_o  output  1  one-cycle count pulse to the seconds counter.
- min_pulse_o  output  1  one-cycle count pulse to the minutes counter.
- hour_pulse_o  output  1  one-cycle count pulse to the hours counter.
- mode_o  output  2  current mode: 0 RUN, 1 SET_HOUR, 2 SET_MIN. Value 3 is never produced.
- blink_o  output  1  display-blink enable for the field being set.

## Operation
- All outputs are registered. In reset, every output is 0, mode is RUN, the prescaler is 0, and all synchronizer and edge registers are 0.
- Buttons:
  - Each button goes through a 2-flop synchronizer followed by a rising-edge detector.
  - A press produces exactly one internal event, however long the button is held.
- Mode FSM:
  - On each mode event, the FSM steps RUN → SET_HOUR → SET_MIN → RUN.
  - The transition from SET_MIN to RUN clears the prescaler to 0.
- Prescaler:
  - Counts 0 to TICKS_PER_SEC-1 and wraps, in every mode.
  - In RUN, the wrap (count == TICKS_PER_SEC-1) sets sec_pulse_o for one cycle.
  - In set modes, sec_pulse_o is held at 0.
- Carry detection:
  - sec_cout_i and min_cout_i are registered every cycle in every mode, giving a previous-value copy of each.
  - A rising edge is input == 1 while the previous value == 0.
  - In RUN, a sec_cout_i edge gives one min_pulse_o, and a min_cout_i edge gives one hour_pulse_o.
  - In set modes, carry edges are discarded and are not deferred.
  - Because the previous-value registers always track their inputs, a flag that is still high when the FSM returns to RUN produces no pulse.
- Increment:
  - In SET_HOUR, an inc event gives one hour_pulse_o.
  - In SET_MIN, an inc event gives one min_pulse_o.
  - In RUN, inc events are ignored.
- Simultaneous events:
  - A mode event and an inc event in the same cycle: the mode change wins and the inc event is dropped.
  - A carry edge and an inc pulse can never target the same output, since carries are active only in RUN.
- blink_o:
  - In SET_HOUR or SET_MIN, blink_o is registered as (prescaler < TICKS_PER_SEC/2).
  - In RUN, blink_o is 0.

## Timing
- sec_pulse_o:
  - Exactly 1 cycle wide, with a period of exactly TICKS_PER_SEC cycles in RUN.
  - First assertion is in cycle TICKS_PER_SEC after reset release, counting the first cycle after release as cycle 1.
  - After SET_MIN → RUN, the first assertion is TICKS_PER_SEC cycles after mode_o returns to 0.
- Carry latency:
  - min_pulse_o and hour_pulse_o assert for the one cycle following the first clk edge that samples the cout input high.
  - With the counter chain attached, min_pulse_o follows sec_pulse_o by 2 cycles, and hour_pulse_o follows min_pulse_o by 2 cycles.
- Button latency:
  - mode_o changes, or the inc pulse asserts, on the 3rd rising edge at which the raw button input is sampled high.
- Reset asserted mid-operation:
  - All outputs go to 0 and mode to RUN immediately, with no waiting for clk.
  - Any in-flight pulse is lost.

## Test plan
All scenarios use TICKS_PER_SEC = 10.

1. Reset release in RUN, run 35 cycles → sec_pulse_o high in cycles 10, 20 and 30 only, each pulse 1 cycle wide; mode_o = 0 throughout.
2. In RUN, raise sec_cout_i and hold it high for 15 cycles, then repeat with min_cout_i → exactly one min_pulse_o, and later exactly one hour_pulse_o, each 1 cycle after the sampling edge; no repeat pulses while the flag stays high.
3. Three mode presses, each 5 cycles long → mode_o goes 0→1→2→0, each change on the 3rd edge after the press. sec_pulse_o = 0 while mode_o ≠ 0, and blink_o toggles with 5 cycles high / 5 cycles low.
4. Set mode:
   - In SET_MIN, press inc twice → exactly two min_pulse_o and zero hour_pulse_o.
   - Raise min_cout_i while still in SET_MIN → no hour_pulse_o.
   - Return to RUN with min_cout_i still high → no hour_pulse_o.
5. Drive the mode and inc buttons with identical waveforms while in SET_HOUR → mode_o becomes 2, no hour_pulse_o and no min_pulse_o.
6. Assert rst (drive it low) for 1 cycle mid-SET_HOUR → all outputs and mode_o read 0 while rst is low, and scenario 1 timing restarts after release.

Source files
------------

// File: rtl/clock_tick_ctrl.sv
// Sequencing controller: second-tick prescaler, carry edge-to-pulse conversion and button-driven time-set FSM.
// Latency: all outputs registered; carry pulse 1 cycle after the sampling edge, button action on the 3rd sampling edge.
// Backpressure: none; pulses are fire-and-forget, and carries/inc events arriving in the wrong mode are dropped.
module clock_tick_ctrl #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic       sec_cout_i,
  input  logic       min_cout_i,
  output logic       sec_pulse_o,
  output logic       min_pulse_o,
  output logic       hour_pulse_o,
  output logic [1:0] mode_o,
  output logic       blink_o
);

  localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] HALF = CW'(TICKS_PER_SEC / 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  mode_t         state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic mode_s1, mode_s2, mode_prev;
  logic inc_s1, inc_s2, inc_prev;
  logic sec_prev, min_prev;

  logic mode_evt, inc_evt, sec_edge, min_edge, run;
  logic sec_nxt, min_nxt, hour_nxt, blink_nxt;

  // One event per press: rising edge of the synchronised button level.
  assign mode_evt = mode_s2 & ~mode_prev;
  assign inc_evt  = inc_s2 & ~inc_prev;
  // Overflow flags are levels; only their rising edge is a carry.
  assign sec_edge = sec_cout_i & ~sec_prev;
  assign min_edge = min_cout_i & ~min_prev;

  // Button synchronisers, edge-detect history and carry previous-value copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_s1   <= 1'b0;
      mode_s2   <= 1'b0;
      mode_prev <= 1'b0;
      inc_s1    <= 1'b0;
      inc_s2    <= 1'b0;
      inc_prev  <= 1'b0;
      sec_prev  <= 1'b0;
      min_prev  <= 1'b0;
    end else begin
      mode_s1   <= mode_btn_i;
      mode_s2   <= mode_s1;
      mode_prev <= mode_s2;
      inc_s1    <= inc_btn_i;
      inc_s2    <= inc_s1;
      inc_prev  <= inc_s2;
      sec_prev  <= sec_cout_i;
      min_prev  <= min_cout_i;
    end
  end

  // Mode register, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= '0;
      sec_pulse_o  <= 1'b0;
      min_pulse_o  <= 1'b0;
      hour_pulse_o <= 1'b0;
      blink_o      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sec_pulse_o  <= sec_nxt;
      min_pulse_o  <= min_nxt;
      hour_pulse_o <= hour_nxt;
      blink_o      <= blink_nxt;
    end
  end

  // Next mode, prescaler step and next output values; a mode event suppresses everything else that cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == LAST) ? '0 : cnt + 1'b1;
    run       = (state == RUN) && !mode_evt;

    if (mode_evt) begin
      case (state)
        RUN:      state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        default: begin
          // Leaving SET_MIN restarts the second so the first tick is a full period away.
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end

    sec_nxt   = run && (cnt == LAST);
    min_nxt   = (run && sec_edge) || ((state == SET_MIN) && inc_evt && !mode_evt);
    hour_nxt  = (run && min_edge) || ((state == SET_HOUR) && inc_evt && !mode_evt);
    blink_nxt = (state_nxt != RUN) && (cnt < HALF);
  end

  assign mode_o = state;

endmodule

// File: tb/tb_clock_tick_ctrl.sv
// Bench for clock_tick_ctrl: directed scenarios followed by random button/carry activity.
// Every cycle all outputs are compared against an edge-indexed history model of the block.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_clock_tick_ctrl;

  localparam int T    = 10;
  localparam int MAXN = 8191;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       sec_cout = 1'b0;
  logic       min_cout = 1'b0;
  logic       sec_pulse, min_pulse, hour_pulse, blink;
  logic [1:0] mode;

  int vectors = 0;
  int errors  = 0;
  int c_sec, c_min, c_hour;

  // Reference model: inputs recorded per rising edge since reset release.
  bit mh [0:MAXN];
  bit ih [0:MAXN];
  bit sh [0:MAXN];
  bit nh [0:MAXN];
  int n, base, m_mode;
  bit e_sec, e_min, e_hour, e_blink;

  clock_tick_ctrl #(.TICKS_PER_SEC(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode_btn_i   (mode_btn),
    .inc_btn_i    (inc_btn),
    .sec_cout_i   (sec_cout),
    .min_cout_i   (min_cout),
    .sec_pulse_o  (sec_pulse),
    .min_pulse_o  (min_pulse),
    .hour_pulse_o (hour_pulse),
    .mode_o       (mode),
    .blink_o      (blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample recorded at edge k; nothing was sampled before the first edge after release.
  function automatic bit h(input int which, input int k);
    if (k < 1) return 1'b0;
    case (which)
      0:       return mh[k];
      1:       return ih[k];
      2:       return sh[k];
      default: return nh[k];
    endcase
  endfunction

  task automatic model_reset();
    n = 0; base = 0; m_mode = 0;
    e_sec = 0; e_min = 0; e_hour = 0; e_blink = 0;
  endtask

  task automatic model_edge();
    bit mev, iev, sedge, medge, run;
    int old, pre;
    n++;
    if (n > MAXN) $fatal(1, "FAIL model_range: edge %0d beyond history %0d", n, MAXN);
    mh[n] = mode_btn; ih[n] = inc_btn; sh[n] = sec_cout; nh[n] = min_cout;
    // A press acts on the 3rd edge that samples it high.
    mev   = h(0, n - 2) && !h(0, n - 3);
    iev   = h(1, n - 2) && !h(1, n - 3);
    sedge = h(2, n) && !h(2, n - 1);
    medge = h(3, n) && !h(3, n - 1);
    old   = m_mode;
    pre   = (n - 1 - base) % T;          // prescaler value seen at this edge
    if (mev) begin
      m_mode = (old + 1) % 3;
      if (old == 2) base = n;
    end
    run     = (old == 0) && !mev;
    e_sec   = run && (pre == T - 1);
    e_min   = (run && sedge) || (old == 2 && !mev && iev);
    e_hour  = (run && medge) || (old == 1 && !mev && iev);
    e_blink = (m_mode != 0) && (pre < T / 2);
  endtask

  task automatic check_all();
    check("sec_pulse",  sec_pulse,  e_sec);
    check("min_pulse",  min_pulse,  e_min);
    check("hour_pulse", hour_pulse, e_hour);
    check("mode",       mode,       m_mode);
    check("blink",      blink,      e_blink);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    c_sec  += int'(sec_pulse === 1'b1);
    c_min  += int'(min_pulse === 1'b1);
    c_hour += int'(hour_pulse === 1'b1);
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic clear_counts();
    c_sec = 0; c_min = 0; c_hour = 0;
  endtask

  task automatic press(input bit m, input bit i, input int len, input int gap);
    mode_btn = m; inc_btn = i;
    idle(len);
    mode_btn = 1'b0; inc_btn = 1'b0;
    idle(gap);
  endtask

  // Asynchronous assert checked before any clock edge, held across one edge, released mid-cycle.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // Ticks after reset release.
    clear_counts();
    idle(35);
    check("sec_count_boot", c_sec, 3);

    // Carry flags held high give a single pulse each.
    clear_counts();
    sec_cout = 1'b1; idle(15); sec_cout = 1'b0; idle(5);
    min_cout = 1'b1; idle(15); min_cout = 1'b0; idle(5);
    check("carry_min_count",  c_min,  1);
    check("carry_hour_count", c_hour, 1);

    // Mode cycling.
    press(1'b1, 1'b0, 5, 12); check("mode_step1", mode, 1);
    press(1'b1, 1'b0, 5, 12); check("mode_step2", mode, 2);
    press(1'b1, 1'b0, 5, 12); check("mode_step3", mode, 0);

    // Increment in SET_MIN, carries ignored in set mode and on return.
    press(1'b1, 1'b0, 4, 6);
    press(1'b1, 1'b0, 4, 6);
    clear_counts();
    press(1'b0, 1'b1, 4, 6);
    press(1'b0, 1'b1, 4, 6);
    check("inc_min_count",  c_min,  2);
    check("inc_hour_count", c_hour, 0);
    min_cout = 1'b1;
    idle(6);
    press(1'b1, 1'b0, 4, 10);
    check("setmin_exit_mode", mode, 0);
    check("stale_carry_hour", c_hour, 0);
    min_cout = 1'b0;
    idle(3);

    // Simultaneous mode and inc in SET_HOUR.
    press(1'b1, 1'b0, 4, 6);
    clear_counts();
    press(1'b1, 1'b1, 5, 10);
    check("simul_mode",  mode,   2);
    check("simul_min",   c_min,  0);
    check("simul_hour",  c_hour, 0);

    // Reset in the middle of SET_HOUR restarts the tick timing.
    press(1'b1, 1'b0, 4, 6);
    press(1'b1, 1'b0, 4, 4);
    check("pre_reset_mode", mode, 1);
    do_reset();
    clear_counts();
    idle(35);
    check("sec_count_rereset", c_sec, 3);

    // Random activity with one reset partway through.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(11) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(5)  == 0) inc_btn  = ~inc_btn;
      if ($urandom_range(7)  == 0) sec_cout = ~sec_cout;
      if ($urandom_range(9)  == 0) min_cout = ~min_cout;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
